cs_out_buffer: RTL and testbench
================================

CS_OUT_BUFFER -- requirements
Module: cs_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count, power of two, 2..64.
REQ-002 SHALL have parameter WARM, default 8, number of initial Y samples discarded while the 9-sample window fills.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_en  input  1  new X was presented to CS this cycle and Y_in is valid.
REQ-006 SHALL have port Y_in  input  10  CS result Y, sampled on the clk edge where in_en=1.
REQ-007 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 SHALL have port ovf_clr  input  1  synchronous clear of the ovf flag.
REQ-009 SHALL have port out_valid  output  1  out_data holds the oldest buffered sample.
REQ-010 SHALL have port out_data  output  10  FIFO head.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full  output  1  count==DEPTH.
REQ-013 SHALL have port warm  output  1  warm-up complete, samples now buffered.
REQ-014 SHALL have port ovf  output  1  sticky flag, at least one sample dropped.
REQ-015 SHALL have port max_y  output  10  largest sample pushed since reset.

Function
REQ-016 SHALL count in_en pulses in a warm-up counter while warm=0; the first WARM samples SHALL be discarded; warm SHALL rise on the edge that accepts sample WARM and stay high until reset.
REQ-017 SHALL treat sample WARM+1 as the first push candidate; push = in_en & warm.
REQ-018 SHALL implement a circular buffer with rd/wr pointers wrapping modulo DEPTH; no bubble at wrap.
REQ-019 SHALL be first-word fall-through: out_valid = (count!=0); out_data = mem[rd_ptr], driven from registers with no combinational path from Y_in.
REQ-020 SHALL pop on out_valid & out_ready; out_ready while empty SHALL have no effect.
REQ-021 SHALL make a sample pushed into an empty buffer at edge N visible with out_valid=1 in the cycle after edge N (latency 1).
REQ-022 SHALL, on push while full without pop, drop Y_in, leave count/pointers unchanged, and set ovf on that edge.
REQ-023 SHALL, on simultaneous push and pop while full, accept both; count stays DEPTH; ovf unchanged.
REQ-024 SHALL, on simultaneous push and pop at any other occupancy, keep count unchanged and advance both pointers.
REQ-025 SHALL clear ovf on ovf_clr=1; a drop in the same cycle as ovf_clr SHALL win (ovf=1).
REQ-026 SHALL hold all state when in_en=0 and no pop occurs.

Reset
REQ-027 SHALL, on reset=0, asynchronously force count=0, pointers=0, warm=0, warm-up counter=0, ovf=0, max_y=0, hence out_valid=0, full=0.
REQ-028 SHALL discard buffered data on reset mid-operation and require a fresh WARM-sample warm-up.
REQ-029 SHALL not reset memory contents; out_data is don't-care while out_valid=0.

Configuration
REQ-030 SHALL, with CS_OUT_MAXTRACK_EN defined, update max_y to Y_in on every accepted push where Y_in > max_y (dropped samples excluded).
REQ-031 SHALL, without CS_OUT_MAXTRACK_EN, keep the max_y port and drive it constant 0 with no comparator logic.

Verification
REQ-032 SHALL cover warm-up: reset, 8 in_en pulses with Y_in=1..8, then Y_in=0x155 -> warm rises on the 8th edge, out_valid=0 before, out_data=0x155 one cycle after the 9th pulse.
REQ-033 SHALL cover fill and drain: out_ready=0, 8 post-warm pushes 0x001..0x008 -> full=1, count=8; then out_ready=1 -> outputs 0x001..0x008 in order on consecutive cycles, then empty.
REQ-034 SHALL cover overflow: full buffer, push 0x3FF without pop -> ovf=1, count=8, 0x3FF never output; ovf_clr -> ovf=0.
REQ-035 SHALL cover full push+pop: full, in_en=1 and out_ready=1 with Y_in=0x0AA -> count stays 8, ovf=0, 0x0AA emerges 8th after the popped word.
REQ-036 SHALL cover reset mid-stream: count=5, reset low for one cycle -> count=0, warm=0, out_valid=0 immediately; the next 8 samples are discarded.
REQ-037 SHALL cover max tracking (macro on): pushes 0x010, 0x200, 0x100 -> max_y=0x010, 0x200, 0x200; macro off -> max_y=0 throughout.

Source files
------------

// File: rtl/cs_out_buffer.sv
// Output FIFO for CS results: discards WARM warm-up samples, then buffers Y in a first-word fall-through FIFO.
// Optional macro CS_OUT_MAXTRACK_EN enables tracking of the largest accepted sample on max_y.
module cs_out_buffer #(
  parameter int DEPTH = 8,
  parameter int WARM  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic [9:0]               Y_in,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  output logic [9:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     warm,
  output logic                     ovf,
  output logic [9:0]               max_y
);

  localparam int DATA_W = 10;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int WW     = ($clog2(WARM + 1) < 1) ? 1 : $clog2(WARM + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [WW-1:0]     warm_cnt;
  logic              push;
  logic              pop;
  logic              accept;
  logic              drop;

  assign push      = in_en & warm;
  assign pop       = out_valid & out_ready;
  // A push into a full buffer is only taken when the head leaves on the same edge.
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      warm     <= 1'b0;
      warm_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (in_en && !warm) begin
        if (warm_cnt == WW'(WARM - 1)) warm <= 1'b1;
        warm_cnt <= warm_cnt + 1'b1;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage is data only: left unreset, content is don't-care while empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= Y_in;
  end

`ifdef CS_OUT_MAXTRACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        max_y <= '0;
    else if (accept && (Y_in > max_y)) max_y <= Y_in;
  end
`else
  assign max_y = '0;
`endif

endmodule

// File: tb/tb_cs_out_buffer.sv
// Scoreboard bench for cs_out_buffer: a queue-based reference model predicts occupancy, flags and output order.
module tb_cs_out_buffer;

  localparam int DEPTH = 8;
  localparam int WARM  = 8;

  logic                   clk;
  logic                   reset;
  logic                   in_en;
  logic [9:0]             Y_in;
  logic                   out_ready;
  logic                   ovf_clr;
  logic                   out_valid;
  logic [9:0]             out_data;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   warm;
  logic                   ovf;
  logic [9:0]             max_y;

  cs_out_buffer #(.DEPTH(DEPTH), .WARM(WARM)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .Y_in(Y_in), .out_ready(out_ready),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_data(out_data), .count(count),
    .full(full), .warm(warm), .ovf(ovf), .max_y(max_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [9:0] mq [$];
  logic [9:0] exp_q [$];
  int         wcnt  = 0;
  bit         mwarm = 0;
  bit         movf  = 0;
  int         mmax  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    wcnt  = 0;
    mwarm = 0;
    movf  = 0;
    mmax  = 0;
  endtask

  task automatic check_status();
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("warm", int'(warm), int'(mwarm));
    chk("ovf", int'(ovf), int'(movf));
    chk("max_y", int'(max_y), mmax);
    if (mq.size() != 0) chk("head", int'(out_data), int'(mq[0]));
  endtask

  // One clock: drive inputs, advance the model, then check state after the edge.
  task automatic step(input bit en, input logic [9:0] y, input bit rdy, input bit clr);
    int         sz;
    bit         pop_m;
    bit         acc;
    logic [9:0] tmp;
    in_en     = en;
    Y_in      = y;
    out_ready = rdy;
    ovf_clr   = clr;
    sz    = mq.size();
    pop_m = (sz > 0) && rdy;
    acc   = en && mwarm && ((sz < DEPTH) || pop_m);
    if (en && mwarm && !acc) movf = 1;
    else if (clr)            movf = 0;
    if (pop_m) tmp = mq.pop_front();
    if (acc) begin
      mq.push_back(y);
      exp_q.push_back(y);
`ifdef CS_OUT_MAXTRACK_EN
      if (int'(y) > mmax) mmax = int'(y);
`endif
    end
    if (en && !mwarm) begin
      wcnt++;
      if (wcnt == WARM) mwarm = 1;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected word.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got 0x%0h expected no output at %0t", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in_en     = 1'b0;
    Y_in      = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status();
    reset = 1'b1;

    // Warm-up: samples 1..8 discarded, 0x155 becomes the first buffered word
    for (int i = 1; i <= WARM; i++) step(1, 10'(i), 0, 0);
    step(1, 10'h155, 0, 0);
    step(0, 10'h0, 1, 0);

    // Fill, overflow and flag clearing
    for (int i = 1; i <= DEPTH; i++) step(1, 10'(i), 0, 0);
    step(1, 10'h3FF, 0, 0);
    step(0, 10'h0, 0, 1);
    step(1, 10'h3FE, 0, 1);
    step(0, 10'h0, 0, 1);

    // Push and pop together while full, then drain
    step(1, 10'h0AA, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 10'h0, 1, 0);
    step(0, 10'h0, 1, 0);

    // Max tracking sequence
    step(1, 10'h010, 0, 0);
    step(1, 10'h200, 0, 0);
    step(1, 10'h100, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 10'h0, 1, 0);

    // Randomized traffic with alternating consumer pressure
    for (int i = 0; i < 400; i++) begin
      bit rdy;
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), rdy,
           ($urandom_range(0, 15) == 0));
    end

    // Reset mid-stream with five words buffered
    for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) step(0, 10'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 10'(16 + i), 0, 0);
    in_en = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_status();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < WARM; i++) step(1, 10'($urandom_range(0, 1023)), 1, 0);
    step(1, 10'h2AB, 0, 0);
    step(1, 10'h0C3, 0, 0);

    // Final drain, bounded
    for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) step(0, 10'h0, 1, 0);
    step(0, 10'h0, 0, 0);
    chk("sb_left", exp_q.size(), 0);
    chk("final_valid", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
